// File: rtl/frame_update_sched.sv
// Per-frame update sequencer: on each selected vblank edge, strobes tubes, birds, collide
// in order, each gated by a step_done handshake. FRAME_SCHED_STATS_EN enables the counters.
module frame_update_sched #(
    parameter int STEP_TIMEOUT = 64,
    parameter int FRAME_DIV    = 1,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_rst,
    input  logic              run,
    input  logic              vblnk,
    input  logic              click_local,
    input  logic              click_remote,
    input  logic              step_done,
    output logic              step_tubes,
    output logic              step_birds,
    output logic              step_collide,
    output logic              flap1,
    output logic              flap2,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] overrun_cnt
);

    // state | meaning
    // WAIT  | idle, counting frame edges through the divider
    // TUBES | step_tubes strobe
    // W_T   | waiting for tubes step_done
    // BIRDS | step_birds strobe, flap flags delivered
    // W_B   | waiting for birds step_done
    // COLL  | step_collide strobe
    // W_C   | waiting for collide step_done
    // DONE  | frame_done pulse
    typedef enum logic [2:0] {WAIT, TUBES, W_T, BIRDS, W_B, COLL, W_C, DONE} state_t;

    localparam int TMR_W = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;
    // Loaded in the strobe cycle so a forced advance lands STEP_TIMEOUT cycles after the strobe.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_TIMEOUT - 2);
    localparam logic [7:0]       DIV_LAST = 8'(FRAME_DIV - 1);

    state_t           state;
    logic             vblnk_q;
    logic [7:0]       div;
    logic [TMR_W-1:0] tmr;
    logic             pend1;
    logic             pend2;
    logic             frame_edge;
    logic             tmr_hit;
    logic             advance;

    assign frame_edge = vblnk & ~vblnk_q;
    assign tmr_hit    = ~step_done & (tmr == '0);
    assign advance    = step_done | (tmr == '0);
    assign busy       = (state != WAIT);
    assign flap1      = step_birds & pend1;
    assign flap2      = step_birds & pend2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT;
            vblnk_q      <= 1'b0;
            div          <= '0;
            tmr          <= '0;
            step_tubes   <= 1'b0;
            step_birds   <= 1'b0;
            step_collide <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            vblnk_q      <= vblnk;
            step_tubes   <= 1'b0;
            step_birds   <= 1'b0;
            step_collide <= 1'b0;
            frame_done   <= 1'b0;
            if (game_rst) begin
                state <= WAIT;
                div   <= '0;
            end else begin
                case (state)
                    WAIT: begin
                        if (frame_edge && run) begin
                            if (div == DIV_LAST) begin
                                div        <= '0;
                                state      <= TUBES;
                                step_tubes <= 1'b1;
                            end else begin
                                div <= div + 8'd1;
                            end
                        end
                    end
                    TUBES: begin
                        state <= W_T;
                        tmr   <= TMR_LOAD;
                    end
                    W_T: begin
                        if (advance) begin
                            state      <= BIRDS;
                            step_birds <= 1'b1;
                            if (tmr_hit) timeout_err <= 1'b1;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    BIRDS: begin
                        state <= W_B;
                        tmr   <= TMR_LOAD;
                    end
                    W_B: begin
                        if (advance) begin
                            state        <= COLL;
                            step_collide <= 1'b1;
                            if (tmr_hit) timeout_err <= 1'b1;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    COLL: begin
                        state <= W_C;
                        tmr   <= TMR_LOAD;
                    end
                    W_C: begin
                        if (advance) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            if (tmr_hit) timeout_err <= 1'b1;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    DONE:    state <= WAIT;
                    default: state <= WAIT;
                endcase
            end
        end
    end

    // Clicks arriving in the BIRDS cycle re-arm the flag for the next frame.
    always_ff @(posedge clk) begin
        if (rst || game_rst || !run) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else if (step_birds) begin
            pend1 <= click_local;
            pend2 <= click_remote;
        end else begin
            pend1 <= pend1 | click_local;
            pend2 <= pend2 | click_remote;
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q;
    logic [STAT_W-1:0] overrun_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
        end else begin
            if (state == DONE && frame_cnt_q != '1)
                frame_cnt_q <= frame_cnt_q + 1'b1;
            if (frame_edge && busy && overrun_cnt_q != '1)
                overrun_cnt_q <= overrun_cnt_q + 1'b1;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
`else
    assign frame_cnt   = '0;
    assign overrun_cnt = '0;
`endif

endmodule
